// File: rtl/hi_wb_regfile.sv
// rtl/hi_wb_regfile.sv - Wishbone register-file slave: ID, scratch, control, status and interrupt registers
module hi_wb_regfile #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int          N_CTRL    = 4,
    parameter int          N_STAT    = 4,
    parameter int          N_IRQ     = 3,
    parameter logic [31:0] ID_VALUE  = 32'h4849_0001
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [32*N_CTRL-1:0]  ctrl_o,
    output logic [N_CTRL-1:0]     ctrl_wr_o,
    input  logic [32*N_STAT-1:0]  status_i,
    input  logic [N_IRQ-1:0]      irq_evt_i,
    output logic [N_IRQ-1:0]      user_irq
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 in_window;
    logic                 req;
    logic                 wr_req;
    logic                 rd_req;
    logic [5:0]           word;
    logic [31:0]          lane_mask;
    logic [31:0]          w_masked;
    logic [31:0]          rd_data;
    logic [31:0]          dat_q;
    logic [31:0]          scratch;
    logic [32*N_CTRL-1:0] ctrl_q;
    logic [N_CTRL-1:0]    ctrl_wr_q;
    logic [N_IRQ-1:0]     irq_status;
    logic [N_IRQ-1:0]     irq_enable;
    logic [N_IRQ-1:0]     irq_clr;
    logic [N_IRQ-1:0]     user_q;
    logic                 unused_adr_lsb;

    // Byte address bits below the word are don't-care
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    assign in_window = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign word      = wbs_adr_i[7:2];
    // ACK state doubles as the registered acknowledge, so a request is only taken from IDLE
    assign req       = wbs_cyc_i & wbs_stb_i & (state == IDLE) & in_window;
    assign wr_req    = req & wbs_we_i;
    assign rd_req    = req & ~wbs_we_i;

    assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_masked  = wbs_dat_i & lane_mask;
    assign irq_clr   = (wr_req && word == 6'd1) ? w_masked[N_IRQ-1:0] : '0;

    assign wbs_ack_o = (state == ACK);
    assign wbs_dat_o = dat_q;
    assign ctrl_o    = ctrl_q;
    assign ctrl_wr_o = ctrl_wr_q;
    assign user_irq  = user_q;

    // Slave state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: one ack per request, then a mandatory idle cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read multiplexer over the register map; unmapped offsets read zero
    always_comb begin
        rd_data = '0;
        if (word == 6'd0) begin
            rd_data = ID_VALUE;
        end else if (word == 6'd1) begin
            rd_data[N_IRQ-1:0] = irq_status;
        end else if (word == 6'd2) begin
            rd_data[N_IRQ-1:0] = irq_enable;
        end else if (word == 6'd3) begin
            rd_data = scratch;
        end
        for (int i = 0; i < N_CTRL; i++) begin
            if (word == 6'(4 + i)) rd_data = ctrl_q[32*i +: 32];
        end
        for (int j = 0; j < N_STAT; j++) begin
            if (word == 6'(16 + j)) rd_data = status_i[32*j +: 32];
        end
    end

    // Read data is held only for the ack cycle and is zero otherwise
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            dat_q <= '0;
        end else begin
            dat_q <= rd_req ? rd_data : '0;
        end
    end

    // Byte-masked writes to RW registers and the per-word write strobe
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            scratch    <= '0;
            irq_enable <= '0;
            ctrl_q     <= '0;
            ctrl_wr_q  <= '0;
        end else begin
            ctrl_wr_q <= '0;
            if (wr_req) begin
                if (word == 6'd2) begin
                    irq_enable <= (irq_enable & ~lane_mask[N_IRQ-1:0]) | w_masked[N_IRQ-1:0];
                end
                if (word == 6'd3) begin
                    scratch <= (scratch & ~lane_mask) | w_masked;
                end
                for (int i = 0; i < N_CTRL; i++) begin
                    if (word == 6'(4 + i)) begin
                        ctrl_q[32*i +: 32] <= (ctrl_q[32*i +: 32] & ~lane_mask) | w_masked;
                        ctrl_wr_q[i]       <= 1'b1;
                    end
                end
            end
        end
    end

    // Sticky interrupt status (a new event beats a same-edge clear) and registered irq outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_status <= '0;
            user_q     <= '0;
        end else begin
            irq_status <= irq_evt_i | (irq_status & ~irq_clr);
            user_q     <= irq_status & irq_enable;
        end
    end

endmodule

// File: tb/tb_hi_wb_regfile.sv
// tb/tb_hi_wb_regfile.sv - self-checking bench for hi_wb_regfile with a behavioural register-map model
module tb_hi_wb_regfile;

    logic         clk = 1'b0;
    logic         rst;
    logic         cyc, stb, we;
    logic [3:0]   sel;
    logic [31:0]  adr, wdat;
    logic         ack;
    logic [31:0]  rdat;
    logic [127:0] ctrl;
    logic [3:0]   ctrl_wr;
    logic [127:0] status;
    logic [2:0]   evt;
    logic [2:0]   uirq;

    always #5 clk = ~clk;

    hi_wb_regfile dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .ctrl_o   (ctrl),
        .ctrl_wr_o(ctrl_wr),
        .status_i (status),
        .irq_evt_i(evt),
        .user_irq (uirq)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_mode = 1'b0;
    bit chk_en = 1'b0;

    // Behavioural model of the register map
    logic [31:0] m_ctrl [4];
    logic [31:0] m_scratch;
    logic [2:0]  m_stat, m_en, m_user;
    logic        m_ack;
    logic [31:0] m_dat;
    logic [3:0]  m_wr;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] off);
        logic [31:0] r;
        r = 32'h0;
        if (off == 8'h00) r = 32'h4849_0001;
        else if (off == 8'h04) r = {29'h0, m_stat};
        else if (off == 8'h08) r = {29'h0, m_en};
        else if (off == 8'h0C) r = m_scratch;
        else if (off >= 8'h10 && off < 8'h20) r = m_ctrl[(off - 8'h10) >> 2];
        else if (off >= 8'h40 && off < 8'h50) r = status[32*((off - 8'h40) >> 2) +: 32];
        return r;
    endfunction

    // Model update at each edge, from pre-edge state and the inputs seen at that edge
    always @(posedge clk) begin : model
        logic        rq;
        logic [7:0]  off;
        logic [31:0] mask, rd;
        logic [2:0]  clr, user_n;
        int          idx;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_ctrl[i] = 32'h0;
            m_scratch = 0; m_stat = 0; m_en = 0; m_user = 0; m_ack = 0; m_dat = 0; m_wr = 0;
        end else begin
            rq  = cyc && stb && !m_ack && (adr[31:8] == 24'h30_0000);
            off = {adr[7:2], 2'b00};
            for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{sel[b]}};
            rd     = m_read(off);
            user_n = m_stat & m_en;
            clr = 0; m_wr = 0; m_dat = 0;
            if (rq && we) begin
                if (off == 8'h04) clr = wdat[2:0] & mask[2:0];
                else if (off == 8'h08) m_en = (m_en & ~mask[2:0]) | (wdat[2:0] & mask[2:0]);
                else if (off == 8'h0C) m_scratch = (m_scratch & ~mask) | (wdat & mask);
                else if (off >= 8'h10 && off < 8'h20) begin
                    idx = int'((off - 8'h10) >> 2);
                    m_ctrl[idx] = (m_ctrl[idx] & ~mask) | (wdat & mask);
                    m_wr[idx] = 1'b1;
                end
            end else if (rq) begin
                m_dat = rd;
            end
            m_stat = (m_stat & ~clr) | evt;
            m_user = user_n;
            m_ack  = rq;
        end
    end

    // Every-cycle comparison of all registered outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", {127'h0, ack}, {127'h0, m_ack});
            check("dat_o", {96'h0, rdat}, {96'h0, m_dat});
            check("ctrl_o", ctrl, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
            check("ctrl_wr_o", {124'h0, ctrl_wr}, {124'h0, m_wr});
            check("user_irq", {125'h0, uirq}, {125'h0, m_user});
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_mode) begin
            evt = 3'($urandom);
            if ($urandom_range(7) == 0) status = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // One classic cycle; returns at the negedge where ack is seen, bus released
    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r, output int lat);
        adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        lat = 0; r = 32'h0;
        do begin
            tick();
            lat++;
        end while (!ack && lat < 8);
        if (!ack) check("ack_timeout", {127'h0, ack}, 128'h1);
        r = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          lat;
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0; status = 0; evt = 0;
        tick(); tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_ack", {127'h0, ack}, 128'h0);
        check("rst_ctrl", ctrl, 128'h0);
        check("rst_uirq", {125'h0, uirq}, 128'h0);
        check("rst_dat", {96'h0, rdat}, 128'h0);

        bus(32'h3000_0000, 0, 0, 4'hF, r, lat);
        check("id_read", {96'h0, r}, 128'h4849_0001);
        check("ack_latency", 128'(lat), 128'd1);
        tick();
        check("ack_width", {127'h0, ack}, 128'h0);
        check("dat_after_ack", {96'h0, rdat}, 128'h0);
        bus(32'h3000_000C, 0, 0, 4'hF, r, lat);
        check("scratch_reset", {96'h0, r}, 128'h0);
        tick();

        bus(32'h3000_0014, 1, 32'hA5A5_A5A5, 4'b0101, r, lat);
        check("ctrl1_value", {96'h0, ctrl[63:32]}, 128'h00A5_00A5);
        check("ctrl_wr_pulse", {124'h0, ctrl_wr}, 128'h2);
        tick();
        check("ctrl_wr_clear", {124'h0, ctrl_wr}, 128'h0);
        bus(32'h3000_0014, 0, 0, 4'hF, r, lat);
        check("ctrl1_readback", {96'h0, r}, 128'h00A5_00A5);
        tick();

        status[95:64] = 32'hDEAD_BEEF;
        bus(32'h3000_0048, 0, 0, 4'hF, r, lat);
        check("status2_read", {96'h0, r}, 128'hDEAD_BEEF);
        tick();
        bus(32'h3000_0048, 1, 32'h1234_5678, 4'hF, r, lat);
        tick();
        bus(32'h3000_0048, 0, 0, 4'hF, r, lat);
        check("status2_ro", {96'h0, r}, 128'hDEAD_BEEF);
        tick();

        bus(32'h3000_0008, 1, 32'h5, 4'hF, r, lat);
        tick();
        evt = 3'b111;
        tick();
        evt = 3'b000;
        tick();
        check("uirq_enabled", {125'h0, uirq}, 128'h5);
        bus(32'h3000_0004, 0, 0, 4'hF, r, lat);
        check("irq_status_all", {96'h0, r}, 128'h7);
        tick();
        bus(32'h3000_0004, 1, 32'h1, 4'hF, r, lat);
        tick();
        check("uirq_after_w1c", {125'h0, uirq}, 128'h4);

        evt = 3'b001;
        tick();
        bus(32'h3000_0004, 1, 32'h1, 4'hF, r, lat);
        tick();
        bus(32'h3000_0004, 0, 0, 4'hF, r, lat);
        check("set_wins", {96'h0, r}, 128'h7);
        evt = 3'b000;
        tick();
        bus(32'h3000_0004, 1, 32'h1, 4'hF, r, lat);
        tick();
        bus(32'h3000_0004, 0, 0, 4'hF, r, lat);
        check("w1c_clears", {96'h0, r}, 128'h6);
        tick();

        adr = 32'h3000_0100; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("out_of_window", {127'h0, ack}, 128'h0);
        end
        cyc = 1'b0; stb = 1'b0;
        tick();
        bus(32'h3000_0030, 0, 0, 4'hF, r, lat);
        check("unmapped_read", {96'h0, r}, 128'h0);
        tick();

        bus(32'h3000_0010, 1, 32'h1234_5678, 4'hF, r, lat);
        check("ctrl0_commit", {96'h0, ctrl[31:0]}, 128'h1234_5678);
        check("uirq_before_rst", {125'h0, uirq}, 128'h4);
        rst = 1'b1;
        tick();
        check("rst_mid_ack", {127'h0, ack}, 128'h0);
        check("rst_mid_ctrl", ctrl, 128'h0);
        check("rst_mid_uirq", {125'h0, uirq}, 128'h0);
        rst = 1'b0;
        tick();

        rand_mode = 1'b1;
        for (int t = 0; t < 400; t++) begin
            logic [31:0] a;
            if ($urandom_range(9) == 0) begin
                a = 32'h3000_0100 + 32'($urandom_range(255));
                adr = a; we = 1'($urandom); sel = 4'($urandom); wdat = $urandom;
                cyc = 1'b1; stb = 1'b1;
                repeat (3) tick();
                cyc = 1'b0; stb = 1'b0;
            end else begin
                a = 32'h3000_0000 + 32'($urandom_range(23) * 4) + 32'($urandom_range(3));
                bus(a, 1'($urandom), $urandom, 4'($urandom), r, lat);
            end
            repeat ($urandom_range(2)) tick();
        end
        rand_mode = 1'b0;
        evt = 3'b000;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
